// File: rtl/wave_meas.sv
// ADC return-path measurement: locks onto a hysteretic rising crossing, then times n periods and tracks peaks.
// Define WAVE_MEAS_SUM_EN to add the sum_out / samp_cnt sample-accumulator outputs.
module wave_meas #(
  parameter int ND   = 14,
  parameter int NP   = 24,
  parameter int NC   = 8,
  parameter int HYST = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ND-1:0]    adc_data,
  input  logic             adc_valid,
  input  logic             start,
  input  logic [ND-1:0]    thresh,
  input  logic [NC-1:0]    n_periods,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [NP-1:0]    period_cyc,
  output logic [ND-1:0]    vmax,
  output logic [ND-1:0]    vmin
`ifdef WAVE_MEAS_SUM_EN
  ,
  output logic [ND+NP-1:0] sum_out,
  output logic [NP-1:0]    samp_cnt
`endif
);

  localparam logic [ND-1:0] HYST_N = ND'(HYST);
  localparam logic [ND:0]   HYST_X = {1'b0, HYST_N};
  localparam logic [ND:0]   DMAX_X = {1'b0, {ND{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ND-1:0] hi_th, lo_th;
  logic [NC-1:0] n_lat;
  logic          low_seen;
  logic [ND-1:0] wmax, wmin;
  logic [NC-1:0] xcnt;
  logic [NP-1:0] cyc, timer;

`ifdef WAVE_MEAS_SUM_EN
  logic [ND+NP-1:0] sum_acc, sum_nxt;
  logic [NP-1:0]    cnt_acc, cnt_nxt;
`endif

  logic [ND:0]   th_up;
  logic [ND-1:0] hi_nxt, lo_nxt;
  logic          is_low, is_rise, tmr_max, last_cross;
  logic [NC-1:0] xcnt_inc;
  logic [NP-1:0] cyc_inc, timer_inc;
  logic [ND-1:0] max_nxt, min_nxt;

  // Saturated crossing levels derived from the requested threshold.
  always_comb begin
    th_up  = {1'b0, thresh} + HYST_X;
    hi_nxt = (th_up > DMAX_X) ? '1 : th_up[ND-1:0];
    lo_nxt = (thresh < HYST_N) ? '0 : thresh - HYST_N;
  end

  always_comb begin
    is_low     = adc_valid && (adc_data <= lo_th);
    is_rise    = adc_valid && low_seen && (adc_data >= hi_th);
    tmr_max    = (timer == '1);
    xcnt_inc   = xcnt + NC'(1);
    last_cross = is_rise && (xcnt_inc == n_lat);
    cyc_inc    = (cyc == '1) ? cyc : cyc + NP'(1);
    timer_inc  = (timer == '1) ? timer : timer + NP'(1);
    max_nxt    = (adc_valid && (adc_data > wmax)) ? adc_data : wmax;
    min_nxt    = (adc_valid && (adc_data < wmin)) ? adc_data : wmin;
  end

`ifdef WAVE_MEAS_SUM_EN
  always_comb begin
    sum_nxt = adc_valid ? sum_acc + (ND+NP)'(adc_data) : sum_acc;
    cnt_nxt = adc_valid ? cnt_acc + NP'(1) : cnt_acc;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout wins over a crossing landing in the same cycle, so period_cyc never saturates.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM: begin
        if (tmr_max)      state_nxt = DONE;
        else if (is_rise) state_nxt = MEAS;
      end
      MEAS:    if (tmr_max || last_cross) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      period_cyc <= '0;
      vmax       <= '0;
      vmin       <= '0;
      hi_th      <= '0;
      lo_th      <= '0;
      n_lat      <= '0;
      low_seen   <= 1'b0;
      wmax       <= '0;
      wmin       <= '0;
      xcnt       <= '0;
      cyc        <= '0;
      timer      <= '0;
`ifdef WAVE_MEAS_SUM_EN
      sum_acc    <= '0;
      cnt_acc    <= '0;
      sum_out    <= '0;
      samp_cnt   <= '0;
`endif
    end else begin
      busy <= (state_nxt == ARM) || (state_nxt == MEAS);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            hi_th    <= hi_nxt;
            lo_th    <= lo_nxt;
            n_lat    <= (n_periods == '0) ? NC'(1) : n_periods;
            low_seen <= 1'b0;
            wmax     <= '0;
            wmin     <= '1;
            xcnt     <= '0;
            cyc      <= '0;
            timer    <= '0;
            timeout  <= 1'b0;
`ifdef WAVE_MEAS_SUM_EN
            sum_acc  <= '0;
            cnt_acc  <= '0;
`endif
          end
        end
        ARM: begin
          timer <= timer_inc;
          if (tmr_max) begin
            timeout <= 1'b1;
          end else if (is_rise) begin
            low_seen <= 1'b0;
            cyc      <= '0;
            wmax     <= max_nxt;
            wmin     <= min_nxt;
`ifdef WAVE_MEAS_SUM_EN
            sum_acc  <= (ND+NP)'(adc_data);
            cnt_acc  <= NP'(1);
`endif
          end else if (is_low) begin
            low_seen <= 1'b1;
          end
        end
        MEAS: begin
          timer <= timer_inc;
          cyc   <= cyc_inc;
          wmax  <= max_nxt;
          wmin  <= min_nxt;
`ifdef WAVE_MEAS_SUM_EN
          sum_acc <= sum_nxt;
          cnt_acc <= cnt_nxt;
`endif
          if (is_rise) begin
            low_seen <= 1'b0;
            xcnt     <= xcnt_inc;
          end else if (is_low) begin
            low_seen <= 1'b1;
          end
          if (tmr_max) begin
            timeout <= 1'b1;
          end else if (last_cross) begin
            period_cyc <= cyc_inc;
            vmax       <= max_nxt;
            vmin       <= min_nxt;
`ifdef WAVE_MEAS_SUM_EN
            sum_out    <= sum_nxt;
            samp_cnt   <= cnt_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wave_meas.md
# wave_meas

Waveform measurement block for the ADC return path of the electrochemical workstation. It is the receive-side counterpart of the DDS waveform generator. On a start pulse it watches the 14-bit ADC sample stream, locks onto a rising mid-level crossing with hysteresis, and then measures over a programmed number of periods. It reports the total period length in clock cycles plus the peak maximum and minimum sample. Results are latched for the controller and held until the next start.

## Interface
- ND, 14, ADC sample width (matches DAC data width)
- NP, 24, cycle/timeout counter width
- NC, 8, period-count width
- HYST, 64, hysteresis half-band in LSBs
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- adc_data  in  ND  unsigned ADC sample
- adc_valid  in  1  adc_data valid this cycle
- start  in  1  single-cycle request to begin a measurement
- thresh  in  ND  crossing level, sampled on accepted start
- n_periods  in  NC  periods to measure, sampled on accepted start; 0 treated as 1
- busy  out  1  high in ARM and MEAS
- done  out  1  one-cycle pulse at end of measurement (normal or timeout)
- timeout  out  1  last measurement aborted by timeout; held until next accepted start
- period_cyc  out  NP  clocks spanning n_periods periods
- vmax  out  ND  maximum sample in window
- vmin  out  ND  minimum sample in window

## Operation
- Thresholds are computed at start and saturated:
  - hi_th = min(thresh+HYST, 2^ND-1)
  - lo_th = max(thresh-HYST, 0)
- Level tracker `low_seen`, updated on valid samples only:
  - Set when a sample is <= lo_th.
  - A rising crossing is a valid sample >= hi_th while low_seen=1. The crossing clears low_seen.
- States: IDLE, ARM, MEAS, DONE.
- IDLE
  - start → ARM.
  - On entry to ARM: latch thresh and n_periods, clear low_seen, working max=0, working min=2^ND-1, crossing count=0, cycle counter=0, timer=0, timeout=0.
- ARM
  - On the first rising crossing → MEAS. Cycle counter is cleared to 0 in that cycle.
  - The crossing sample is included in working min/max.
- MEAS
  - Cycle counter increments every clock.
  - Every valid sample updates working min/max.
  - Each rising crossing increments the crossing count.
  - On the crossing that brings the count to n_periods: period_cyc ← cycle counter+1, vmax/vmin ← working values including that sample → DONE.
- DONE
  - done=1 for one cycle → IDLE.
- Timeout
  - The timer increments every clock in ARM and MEAS.
  - When it reaches 2^NP-1: timeout=1, done=1 next cycle via DONE.
  - period_cyc, vmax and vmin keep their previous values.
- start outside IDLE is ignored.
- Samples with adc_valid=0 are ignored by the tracker and min/max; the clock-based counters still run.

## Timing
- Reset values: busy 0, done 0, timeout 0, period_cyc 0, vmax 0, vmin 0, state IDLE, all working registers cleared.
- Reset mid-measurement aborts immediately. No done pulse is produced.
- start accepted in cycle t → busy=1 from t+1.
- Final crossing sample in cycle t → results and state DONE registered at t+1. done=1 in t+1, busy=0 from t+1.
- All outputs are registered. No combinational path from inputs to outputs.
- Counter arithmetic is unsigned. Cycle counter and timer saturate and never wrap. A cycle count reaching 2^NP-1 coincides with timeout.

## Configuration
- WAVE_MEAS_SUM_EN defined:
  - Adds output `sum_out` (ND+NP bits): the sum of all valid samples accepted in MEAS, including the first crossing sample.
  - Adds output `samp_cnt` (NP bits): the number of those samples.
  - Both are latched at DONE alongside vmax/vmin, reset to 0, and untouched on timeout.
- Undefined: both ports and their accumulators are absent. All other behaviour is identical.

## Test plan
- Square wave, 0/16383 alternating every 50 clocks, adc_valid=1, thresh=8192, n_periods=4:
  - done one cycle after the 5th rising edge
  - period_cyc=400, vmax=16383, vmin=0, timeout=0
- Triangle 0→16382→0, period 2^15/freq clocks with freq=32 (1024 clocks), n_periods=2, thresh=8192:
  - period_cyc=2048 ±1
  - vmax ≥16350, vmin ≤32
- Noise rejection: square wave with ±40 LSB glitches around 8192 (inside HYST=64):
  - no extra crossings counted
  - period_cyc matches the clean-wave value
- NP=10, constant input 5000, thresh=8192, start:
  - done and timeout=1 exactly 1024 cycles after busy rises
  - previous period_cyc, vmax and vmin unchanged
- start pulses during busy ignored; n_periods=0 behaves as 1. Assert rst mid-MEAS:
  - all outputs return to 0 the same cycle
  - no done pulse
- With WAVE_MEAS_SUM_EN, square wave 0/1000 every 10 clocks, thresh=500, n_periods=1:
  - samp_cnt=21, sum_out=11000
